periph_decoder: RTL and testbench
=================================

PERIPH_DECODER -- requirements
Module: periph_decoder

Interface
REQ-001 Parameter N_SLOTS, 7: number of peripheral slots (1..15); enable bit N_SLOTS is the default slot (RAM).
REQ-002 Parameter REGION_BASE, 32'hffff0000: base of the peripheral region; must be aligned to 2^(ADDR_LSB+IDX_W).
REQ-003 Parameter ADDR_LSB, 4: log2 of slot size in bytes.
REQ-004 Parameter TIMEOUT_CYCLES, 64: wait cycles before a bus error; legal range 2..65535.
REQ-005 Derived constant IDX_W = $clog2(N_SLOTS+1).
REQ-006 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-007 Port resetn, input, 1: asynchronous active-low reset.
REQ-008 Port mem_valid, input, 1: CPU request valid; held until mem_ready is seen.
REQ-009 Port mem_addr, input, 32: request address; sampled only on accept.
REQ-010 Port slave_ready, input, N_SLOTS+1: per-slot completion; bit N_SLOTS is the default slot.
REQ-011 Port enables, output, N_SLOTS+1: registered one-hot select; all zero when idle.
REQ-012 Port mem_ready, output, 1: one-cycle completion pulse to CPU.
REQ-013 Port bus_err, output, 1: one-cycle pulse, coincident with mem_ready, on timeout.

Function
REQ-014 States SHALL be IDLE, ACTIVE and DONE.
REQ-015 IDLE with mem_valid=1 SHALL accept: decode mem_addr, load enables, go to ACTIVE; enables are visible the cycle after mem_valid is first seen.
REQ-016 Decode: if mem_addr[31:ADDR_LSB+IDX_W] matches REGION_BASE and idx = mem_addr[ADDR_LSB+:IDX_W] < N_SLOTS, enables[idx]=1; otherwise enables[N_SLOTS]=1.
REQ-017 Exactly one enables bit SHALL be high in ACTIVE; none in IDLE or DONE.
REQ-018 mem_addr changes during ACTIVE SHALL be ignored.
REQ-019 ACTIVE with slave_ready bit of the selected slot high SHALL assert mem_ready for one cycle (registered, next cycle), clear enables and enter DONE.
REQ-020 slave_ready bits of unselected slots SHALL be ignored.
REQ-021 DONE SHALL last one cycle and return to IDLE; a mem_valid held during DONE is not accepted until IDLE.
REQ-022 mem_valid dropping in ACTIVE SHALL abort: enables cleared, IDLE next cycle, no mem_ready, no bus_err.
REQ-023 Wait counter SHALL clear on accept and increment each ACTIVE cycle without a selected ready; width $clog2(TIMEOUT_CYCLES+1), never wraps.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 without a ready, mem_ready and bus_err SHALL pulse together next cycle, enables clear, state goes to DONE.
REQ-025 Ready and timeout in the same cycle: ready wins, bus_err=0.

Reset
REQ-026 resetn=0 SHALL immediately force state IDLE, enables=0, mem_ready=0, bus_err=0, counter=0, including mid-transaction.
REQ-027 The first accept SHALL occur no earlier than the first rising edge after resetn deasserts.

Configuration
REQ-028 Macro PERIPH_DECODER_TIMEOUT_EN defined: the counter and REQ-023..025 are compiled in.
REQ-029 Macro undefined: no counter logic, bus_err tied 0, ACTIVE waits indefinitely for ready or abort.

Structure
REQ-030 Package periph_decoder_pkg SHALL hold the state enum (IDLE, ACTIVE, DONE) and default parameter constants.
REQ-031 The wait counter SHALL be sub-module periph_timeout (clk, resetn, clear, count_en, expired), instantiated only under PERIPH_DECODER_TIMEOUT_EN.

Verification
REQ-032 Slot decode: mem_valid=1, addr=32'hffff0024 -> enables=8'h04 next cycle; slave_ready[2]=1 -> mem_ready pulses 1 cycle, enables=0.
REQ-033 Default/out-of-range decode: addr=32'h00001000, then 32'hffff0074 (idx 7) -> enables=8'h80 for both; ready via slave_ready[7].
REQ-034 Wrong-slot ready: select slot 1, assert slave_ready[3] only -> no mem_ready; then slave_ready[1] -> mem_ready.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=64): select slot 0, never ready -> mem_ready=bus_err=1 exactly 64 cycles after enables rises; ready in cycle 64 instead -> bus_err=0.
REQ-036 Abort and reset: drop mem_valid in ACTIVE -> enables=0 next cycle, no mem_ready; pulse resetn low mid-ACTIVE -> all outputs 0 immediately, next accept behaves normally.
REQ-037 Back-to-back: mem_valid held high across DONE -> second enables rises two cycles after the first mem_ready.

Source files
------------

// File: rtl/periph_decoder_pkg.sv
// rtl/periph_decoder_pkg.sv - state encoding and default configuration for periph_decoder
package periph_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int          DEF_N_SLOTS        = 7;
  localparam logic [31:0] DEF_REGION_BASE    = 32'hffff0000;
  localparam int          DEF_ADDR_LSB       = 4;
  localparam int          DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/periph_timeout.sv
// rtl/periph_timeout.sv - saturating wait counter for periph_decoder (used under PERIPH_DECODER_TIMEOUT_EN)
module periph_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at LAST so the count can never wrap back into a non-expired value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/periph_decoder.sv
// rtl/periph_decoder.sv - address decoder / bus-cycle tracker for peripheral slots plus default RAM slot
// Optional bus-error timeout is compiled in when PERIPH_DECODER_TIMEOUT_EN is defined.
module periph_decoder
  import periph_decoder_pkg::*;
#(
  parameter int          N_SLOTS        = DEF_N_SLOTS,
  parameter logic [31:0] REGION_BASE    = DEF_REGION_BASE,
  parameter int          ADDR_LSB       = DEF_ADDR_LSB,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic [31:0]        mem_addr,
  input  logic [N_SLOTS:0]   slave_ready,
  output logic [N_SLOTS:0]   enables,
  output logic               mem_ready,
  output logic               bus_err
);

  localparam int IDX_W  = $clog2(N_SLOTS + 1);
  localparam int HI_LSB = ADDR_LSB + IDX_W;

  state_t           state;
  state_t           state_next;
  logic [N_SLOTS:0] enables_next;
  logic [N_SLOTS:0] decoded;
  logic [IDX_W-1:0] idx;
  logic             mem_ready_next;
  logic             sel_ready;
  logic             expired;
  logic             timeout_hit;
  logic             accept;

  assign idx       = mem_addr[ADDR_LSB +: IDX_W];
  assign sel_ready = |(slave_ready & enables);
  assign accept    = (state == IDLE) && mem_valid;

  // Anything outside the region, or an index past the last slot, falls to RAM.
  always_comb begin
    decoded = '0;
    if ((mem_addr[31:HI_LSB] == REGION_BASE[31:HI_LSB]) && (int'(idx) < N_SLOTS)) begin
      decoded[idx] = 1'b1;
    end else begin
      decoded[N_SLOTS] = 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    enables_next   = enables;
    mem_ready_next = 1'b0;
    timeout_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          state_next   = ACTIVE;
          enables_next = decoded;
        end
      end
      ACTIVE: begin
        if (!mem_valid) begin
          state_next   = IDLE;
          enables_next = '0;
        end else if (sel_ready || expired) begin
          state_next     = DONE;
          enables_next   = '0;
          mem_ready_next = 1'b1;
          timeout_hit    = !sel_ready;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        enables_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      enables   <= '0;
      mem_ready <= 1'b0;
    end else begin
      state     <= state_next;
      enables   <= enables_next;
      mem_ready <= mem_ready_next;
    end
  end

`ifdef PERIPH_DECODER_TIMEOUT_EN
  periph_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (accept),
    .count_en ((state == ACTIVE) && mem_valid && !sel_ready),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout_hit;
    end
  end
`else
  logic [32:0] unused_cfg;

  assign expired    = 1'b0;
  assign bus_err    = 1'b0;
  assign unused_cfg = {accept, 32'(TIMEOUT_CYCLES)};
`endif

  logic unused_lsb;
  assign unused_lsb = ^mem_addr[ADDR_LSB-1:0];

endmodule

// File: tb/tb_periph_decoder.sv
// tb/tb_periph_decoder.sv - self-checking bench for periph_decoder (timeout cases under PERIPH_DECODER_TIMEOUT_EN)
module tb_periph_decoder;

  localparam int          N_SLOTS = 7;
  localparam logic [31:0] BASE    = 32'hffff0000;
  localparam int          TMO     = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [7:0]  slave_ready = 8'h0;
  logic [7:0]  enables;
  logic        mem_ready;
  logic        bus_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  periph_decoder #(
    .N_SLOTS        (N_SLOTS),
    .REGION_BASE    (BASE),
    .ADDR_LSB       (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .slave_ready (slave_ready),
    .enables     (enables),
    .mem_ready   (mem_ready),
    .bus_err     (bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  exp_en;
    int          wait_n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] en, input logic rdy, input logic err);
    chk({name, " enables"}, 32'(enables), 32'(en));
    chk({name, " mem_ready"}, 32'(mem_ready), 32'(rdy));
    chk({name, " bus_err"}, 32'(bus_err), 32'(err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: slot size 16 bytes, 8 index values per 128-byte window.
  function automatic logic [7:0] exp_slot(input logic [31:0] a);
    int unsigned idx;
    idx = (a / 16) % 8;
    if (((a / 128) == (BASE / 128)) && (idx < N_SLOTS)) return 8'(1 << idx);
    return 8'h80;
  endfunction

  task automatic txn(input string name, input logic [31:0] addr, input logic [7:0] e,
                     input int wait_n, input bit abort);
    mem_valid   = 1'b1;
    mem_addr    = addr;
    slave_ready = 8'h0;
    step();
    chk_out({name, " accept"}, e, 1'b0, 1'b0);
    mem_addr = ~addr;
    for (int i = 0; i < wait_n; i++) begin
      slave_ready = 8'($urandom) & ~e;
      step();
      chk_out({name, " wait"}, e, 1'b0, 1'b0);
    end
    if (abort) begin
      mem_valid   = 1'b0;
      slave_ready = 8'($urandom);
      step();
      chk_out({name, " abort"}, 8'h0, 1'b0, 1'b0);
    end else begin
      slave_ready = 8'($urandom) | e;
      step();
      chk_out({name, " done"}, 8'h0, 1'b1, 1'b0);
      mem_valid   = 1'b0;
      slave_ready = 8'h0;
      step();
      chk_out({name, " idle"}, 8'h0, 1'b0, 1'b0);
    end
    slave_ready = 8'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{32'hffff0024, 8'h04, 0};
    vecs[1] = '{32'h00001000, 8'h80, 2};
    vecs[2] = '{32'hffff0074, 8'h80, 1};
    vecs[3] = '{32'hffff0000, 8'h01, 3};
    vecs[4] = '{32'hffff0064, 8'h40, 0};
    vecs[5] = '{32'hffff0080, 8'h80, 0};
    vecs[6] = '{32'hfffe0010, 8'h80, 1};
    vecs[7] = '{32'hffff0014, 8'h02, 5};
    vecs[8] = '{32'hffff007f, 8'h80, 0};

    // Reset, with a request already pending when reset releases.
    mem_valid = 1'b1;
    mem_addr  = 32'hffff0024;
    repeat (3) begin
      step();
      chk_out("reset", 8'h0, 1'b0, 1'b0);
    end
    resetn = 1'b1;
    #2;
    chk_out("post-reset pre-edge", 8'h0, 1'b0, 1'b0);
    step();
    chk_out("first accept", 8'h04, 1'b0, 1'b0);
    slave_ready = 8'h04;
    step();
    chk_out("first done", 8'h0, 1'b1, 1'b0);
    mem_valid   = 1'b0;
    slave_ready = 8'h0;
    step();

    foreach (vecs[i]) txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_en, vecs[i].wait_n, 1'b0);

    // Wrong-slot ready only, then the right one.
    mem_valid = 1'b1;
    mem_addr  = 32'hffff0010;
    step();
    chk_out("wrong-slot accept", 8'h02, 1'b0, 1'b0);
    slave_ready = 8'h08;
    repeat (3) begin
      step();
      chk_out("wrong-slot ready", 8'h02, 1'b0, 1'b0);
    end
    slave_ready = 8'h02;
    step();
    chk_out("right-slot ready", 8'h0, 1'b1, 1'b0);

    // Back-to-back: valid stays high across DONE.
    mem_addr    = 32'hffff0060;
    slave_ready = 8'h0;
    step();
    chk_out("b2b done->idle", 8'h0, 1'b0, 1'b0);
    step();
    chk_out("b2b second accept", 8'h40, 1'b0, 1'b0);
    slave_ready = 8'h40;
    step();
    chk_out("b2b second done", 8'h0, 1'b1, 1'b0);
    mem_valid   = 1'b0;
    slave_ready = 8'h0;
    step();

    // Reset mid-ACTIVE and mid-DONE.
    mem_valid = 1'b1;
    mem_addr  = 32'hffff0014;
    step();
    step();
    resetn = 1'b0;
    #1;
    chk_out("reset mid-active", 8'h0, 1'b0, 1'b0);
    step();
    resetn = 1'b1;
    step();
    chk_out("accept after reset", 8'h02, 1'b0, 1'b0);
    slave_ready = 8'h02;
    step();
    chk_out("done after reset", 8'h0, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    chk_out("reset mid-done", 8'h0, 1'b0, 1'b0);
    mem_valid   = 1'b0;
    slave_ready = 8'h0;
    step();
    resetn = 1'b1;
    step();

`ifdef PERIPH_DECODER_TIMEOUT_EN
    mem_valid = 1'b1;
    mem_addr  = 32'hffff0000;
    step();
    chk_out("timeout accept", 8'h01, 1'b0, 1'b0);
    for (int k = 1; k < TMO; k++) begin
      step();
      chk_out($sformatf("timeout wait %0d", k), 8'h01, 1'b0, 1'b0);
    end
    step();
    chk_out("timeout fires", 8'h0, 1'b1, 1'b1);
    mem_valid = 1'b0;
    step();
    chk_out("timeout idle", 8'h0, 1'b0, 1'b0);

    mem_valid = 1'b1;
    step();
    for (int k = 1; k < TMO; k++) step();
    chk_out("ready-at-limit wait", 8'h01, 1'b0, 1'b0);
    slave_ready = 8'h01;
    step();
    chk_out("ready wins over timeout", 8'h0, 1'b1, 1'b0);
    mem_valid   = 1'b0;
    slave_ready = 8'h0;
    step();
`else
    mem_valid = 1'b1;
    mem_addr  = 32'hffff0000;
    step();
    repeat (TMO + 36) step();
    chk_out("no-timeout long wait", 8'h01, 1'b0, 1'b0);
    slave_ready = 8'h01;
    step();
    chk_out("no-timeout done", 8'h0, 1'b1, 1'b0);
    mem_valid   = 1'b0;
    slave_ready = 8'h0;
    step();
`endif

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? BASE + 32'($urandom_range(0, 127)) : 32'($urandom);
      txn($sformatf("rand%0d", t), a, exp_slot(a), $urandom_range(0, 8), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
